// File: rtl/fifo_uart_streamer_pkg.sv
// Shared definitions for the FIFO-to-UART word streamer.
// State encodings and the default frame header byte.
package fifo_uart_streamer_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_SEND  = 2'd3;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_FETCH = ST_FETCH,
      S_WAIT  = ST_WAIT,
      S_SEND  = ST_SEND
   } state_e;

endpackage

// File: rtl/fifo_uart_streamer_tx.sv
// UART 8N1 byte transmitter; o_done pulses in the last stop-bit cycle.
// A start request in that same cycle chains the next byte with no gap.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [7:0] i_byte,
   output logic       o_tx,
   output logic       o_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic          busy_q, busy_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [8:0]    sh_q, sh_d;
   logic          tx_q, tx_d;
   logic          tick;

   always_comb begin
      tick   = busy_q && (cnt_q == LAST);
      o_done = tick && (bit_q == 4'd9);
      busy_d = busy_q;
      cnt_d  = cnt_q;
      bit_d  = bit_q;
      sh_d   = sh_q;
      tx_d   = tx_q;
      if (busy_q && !tick) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (tick && !o_done) begin
         cnt_d = '0;
         bit_d = bit_q + 4'd1;
         tx_d  = sh_q[0];
         sh_d  = {1'b1, sh_q[8:1]};
      end
      if (o_done) begin
         busy_d = 1'b0;
         tx_d   = 1'b1;
      end
      // bit 0 is the start bit, 1..8 data, 9 stop
      if (i_start && (!busy_q || o_done)) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         bit_d  = '0;
         tx_d   = 1'b0;
         sh_d   = {1'b1, i_byte};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         bit_q  <= '0;
         sh_q   <= '1;
         tx_q   <= 1'b1;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         bit_q  <= bit_d;
         sh_q   <= sh_d;
         tx_q   <= tx_d;
      end
   end

   assign o_tx = tx_q;

endmodule

// File: rtl/fifo_uart_streamer.sv
// Drains 32-bit FIFO words and sends each as a 5-byte UART frame:
// sync byte, then the word MSB byte first.
module fifo_uart_streamer
   import fifo_uart_streamer_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 434,
   parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
   parameter int          RD_LATENCY   = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic        i_available,
   input  logic [31:0] i_data,
   output logic        o_rdreq,
   output logic        o_tx,
   output logic        o_busy,
   output logic [15:0] o_word_count
);

   localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

   state_e      state_q, state_d;
   logic [1:0]  lat_q, lat_d;
   logic [31:0] word_q, word_d;
   logic [2:0]  idx_q, idx_d;
   logic        launch_q, launch_d;
   logic [15:0] wcnt_q, wcnt_d;
   logic        start;
   logic [7:0]  tx_byte;
   logic        byte_done;

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      word_d   = word_q;
      idx_d    = idx_q;
      launch_d = launch_q;
      wcnt_d   = wcnt_q;
      o_rdreq  = 1'b0;
      start    = 1'b0;
      tx_byte  = SYNC_BYTE;
      unique case (state_q)
         S_IDLE: begin
            if (i_enable && i_available && !i_rst) begin
               o_rdreq = 1'b1;
               lat_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH, S_WAIT: begin
            if (lat_q == LAT_LAST) begin
               word_d   = i_data;
               idx_d    = '0;
               launch_d = 1'b1;
               state_d  = S_SEND;
            end else begin
               lat_d   = lat_q + 2'd1;
               state_d = S_WAIT;
            end
         end
         S_SEND: begin
            // idx_q is the byte in flight; data bytes shift out of word_q
            if (launch_q) begin
               start    = 1'b1;
               launch_d = 1'b0;
            end else if (byte_done) begin
               if (idx_q == 3'd4) begin
                  wcnt_d  = wcnt_q + 16'd1;
                  state_d = S_IDLE;
               end else begin
                  start   = 1'b1;
                  tx_byte = word_q[31:24];
                  word_d  = {word_q[23:0], 8'h00};
                  idx_d   = idx_q + 3'd1;
               end
            end
         end
      endcase
      o_busy = o_rdreq || (state_q != S_IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         lat_q    <= '0;
         word_q   <= '0;
         idx_q    <= '0;
         launch_q <= 1'b0;
         wcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         word_q   <= word_d;
         idx_q    <= idx_d;
         launch_q <= launch_d;
         wcnt_q   <= wcnt_d;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_start(start),
      .i_byte (tx_byte),
      .o_tx   (o_tx),
      .o_done (byte_done)
   );

   assign o_word_count = wcnt_q;

endmodule
